uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares the single uart_tx_8n1 transmitter between NREQ byte producers, e.g. the core debug-register dump and a future store-to-MMIO path.
- Replaces the free-running counter trigger in the core with explicit per-requester valid/ready handshakes.
- Arbitration is round-robin. Accepted bytes are buffered in a small FIFO.
- A sequencer FSM drives senddata/txbyte and waits for txdone.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DEPTH, 8, FIFO depth in bytes (power of 2, at least 2).
- TIMEOUT, 4096, maximum cycles in BUSY without txdone before abort (at least 16).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  requester i presents a byte.
- req_data  in  8*NREQ  byte of requester i in bits [8i+7:8i].
- req_ready  out  NREQ  one-hot grant; the byte is accepted when valid&ready on a clk edge.
- txbyte  out  8  byte to uart_tx_8n1.
- senddata  out  1  one-cycle start pulse to uart_tx_8n1.
- txdone  in  1  one-cycle pulse from uart_tx_8n1 when a frame completes.
- tx_src  out  $clog2(NREQ) (min 1)  source id of the byte currently on txbyte.
- busy  out  1  FSM not in IDLE, or FIFO not empty.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- sent_count  out  16  frames completed; wraps at 0xFFFF->0.
- tx_timeout  out  1  sticky; set on a BUSY timeout, cleared only by rst.

Behaviour:
- Reset values:
  - req_ready=0, txbyte=0, senddata=0, tx_src=0.
  - busy=0, fifo_count=0, sent_count=0, tx_timeout=0.
  - FIFO flushed, FSM=IDLE, round-robin pointer=0.
- Reset mid-frame does not abort a frame already inside uart_tx_8n1; any txdone arriving after reset is ignored.
- Arbitration (combinational req_ready):
  - Grant goes to the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - A grant is given only when push is allowed: fifo_count<DEPTH, or a pop occurs in the same cycle.
  - req_ready is never high for a requester whose req_valid is low.
  - At most one grant per cycle.
  - After an accepted transfer, rr_ptr <= (granted index + 1) mod NREQ. rr_ptr is unchanged when nothing is accepted.
- FIFO:
  - Each entry stores {src id, byte}.
  - Push and pop are allowed in the same cycle, including at full.
  - There is no bypass: a byte pushed at edge t is first visible to the FSM in the cycle after edge t.
- FSM states:
  - IDLE:
    - If the FIFO is not empty, at the next edge: txbyte<=head.byte, tx_src<=head.src, senddata<=1, pop, go to BUSY.
    - Minimum latency: handshake at edge t, senddata high in the cycle after edge t+1.
  - BUSY:
    - senddata is forced to 0 after its single high cycle.
    - A timer counts the cycles spent in BUSY.
    - On txdone: sent_count increments.
      - FIFO not empty: reload immediately (same action as IDLE, back-to-back, timer cleared) and stay in BUSY.
      - FIFO empty: go to IDLE.
    - Timer reaches TIMEOUT-1 without txdone: set tx_timeout, go to IDLE, sent_count unchanged.
- txdone while in IDLE is ignored.
- senddata is never high in two consecutive cycles.
- txbyte holds its value until the next load.
- Width rules:
  - sent_count wraps silently.
  - fifo_count never exceeds DEPTH.
  - Read and write pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared header rv_defs.vh holds:
  - FSM state encodings: ARB_IDLE=1'b0, ARB_BUSY=1'b1.
  - Default DEPTH and TIMEOUT constants.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH), with:
  - push/pop/din/dout/count/full/empty.
  - Synchronous active-high reset.
- The arbiter and FSM stay in uart_tx_arbiter.

Test Plan:
- Single byte: req_valid[0]=1, data 0x41, FIFO empty.
  - Expect req_ready[0] that cycle.
  - Expect senddata=1 for exactly one cycle, in the cycle after edge t+1, with txbyte=0x41 and tx_src=0.
  - After the txdone pulse: sent_count=1, busy=0.
- Round-robin fairness: both requesters hold valid continuously (0xA0.., 0xB0.. incrementing).
  - Expect grants in the order 0,1,0,1,...
  - Expect the transmitted byte order A0,B0,A1,B1.
- Full FIFO: DEPTH=8 and txdone withheld.
  - After 8 accepts plus 1 load, fifo_count=8 and req_ready=0.
  - A txdone pulse gives one back-to-back reload with no IDLE cycle; a push the same cycle keeps fifo_count=8.
- Timeout: txdone never pulses after a load.
  - After TIMEOUT cycles: tx_timeout=1, FSM in IDLE, next FIFO byte loaded, sent_count unchanged.
  - tx_timeout stays set until rst.
- Reset mid-operation: assert rst with 3 bytes queued while in BUSY.
  - Next cycle: fifo_count=0, senddata=0, busy=0, req_ready=0.
  - A subsequent stray txdone leaves sent_count=0.
- Spurious txdone pulses in IDLE: sent_count stays 0 and senddata stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter: sequencer state encoding,
// default sizing constants and a small id-width helper.
package uart_tx_arbiter_pkg;

    localparam int unsigned ARB_DEPTH_DEFAULT   = 32'd8;
    localparam int unsigned ARB_TIMEOUT_DEFAULT = 32'd4096;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of a field able to name n sources; a single source still gets one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with simultaneous push/pop (also when full) and no
// write-to-read bypass; occupancy is reported as a full-range count.
module sync_fifo
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned DEPTH = ARB_DEPTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 32'd1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Qualify requests and advance pointers; a pop frees the slot a full push needs.
    always_comb begin
        pop_ok_s  = pop && !empty;
        push_ok_s = push && (!full || pop_ok_s);
        wr_ptr_d  = push_ok_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d   = count_q + CW'(push_ok_s) - CW'(pop_ok_s);
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: entries are only ever read once the count covers them.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx_8n1 between NREQ byte producers,
// with a byte FIFO and a load/wait sequencer driving senddata/txbyte.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 32'd2,
    parameter int unsigned DEPTH   = ARB_DEPTH_DEFAULT,
    parameter int unsigned TIMEOUT = ARB_TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [8*NREQ-1:0]             req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [7:0]                    txbyte,
    output logic                          senddata,
    input  logic                          txdone,
    output logic [id_width(NREQ)-1:0]     tx_src,
    output logic                          busy,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic [15:0]                   sent_count,
    output logic                          tx_timeout
);

    localparam int unsigned SW = id_width(NREQ);
    localparam int unsigned CW = $clog2(DEPTH) + 32'd1;
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam int unsigned EW = SW + 32'd8;

    arb_state_e     state_q, state_d;
    logic [7:0]     txbyte_q, txbyte_d;
    logic [SW-1:0]  tx_src_q, tx_src_d;
    logic           senddata_q, senddata_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [15:0]    sent_q, sent_d;
    logic           tmo_q, tmo_d;
    logic [SW-1:0]  rr_ptr_q, rr_ptr_d;

    logic           grant_found_s;
    logic [SW-1:0]  grant_idx_s;
    logic [NREQ-1:0] req_ready_s;
    logic           push_s;
    logic           pop_s;
    logic           done_s;
    logic [EW-1:0]  fifo_din_s;
    logic [EW-1:0]  fifo_dout_s;
    logic [CW-1:0]  fifo_count_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;

    function automatic logic [SW-1:0] rr_index(input logic [SW-1:0] base, input int unsigned k);
        return SW'((32'(base) + k) % NREQ);
    endfunction

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .din   (fifo_din_s),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (!grant_found_s && req_valid[rr_index(rr_ptr_q, k)]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = rr_index(rr_ptr_q, k);
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Grant only when the FIFO can take the byte this cycle; held off during reset.
    always_comb begin
        req_ready_s = '0;
        push_s      = 1'b0;
        if (grant_found_s && (!fifo_full_s || pop_s) && !rst) begin
            req_ready_s[grant_idx_s] = 1'b1;
            push_s                   = 1'b1;
        end else begin
            push_s = 1'b0;
        end
        rr_ptr_d   = push_s ? SW'((32'(grant_idx_s) + 32'd1) % NREQ) : rr_ptr_q;
        fifo_din_s = {grant_idx_s, req_data[{grant_idx_s, 3'b000} +: 8]};
    end

    // Sequencer next state; a frame cannot finish in the cycle it is started.
    always_comb begin
        state_d    = state_q;
        txbyte_d   = txbyte_q;
        tx_src_d   = tx_src_q;
        senddata_d = 1'b0;
        timer_d    = timer_q;
        sent_d     = sent_q;
        tmo_d      = tmo_q;
        pop_s      = 1'b0;
        done_s     = txdone && !senddata_q;
        case (state_q)
            ARB_IDLE: begin
                timer_d = '0;
                if (!fifo_empty_s) begin
                    txbyte_d   = fifo_dout_s[7:0];
                    tx_src_d   = fifo_dout_s[EW-1:8];
                    senddata_d = 1'b1;
                    pop_s      = 1'b1;
                    state_d    = ARB_BUSY;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
            ARB_BUSY: begin
                if (done_s) begin
                    sent_d  = sent_q + 16'd1;
                    timer_d = '0;
                    if (!fifo_empty_s) begin
                        txbyte_d   = fifo_dout_s[7:0];
                        tx_src_d   = fifo_dout_s[EW-1:8];
                        senddata_d = 1'b1;
                        pop_s      = 1'b1;
                        state_d    = ARB_BUSY;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else if (timer_q == TW'(TIMEOUT - 32'd1)) begin
                    tmo_d   = 1'b1;
                    timer_d = '0;
                    state_d = ARB_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                timer_d = '0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Sequencer, output and round-robin registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            txbyte_q   <= 8'h00;
            tx_src_q   <= '0;
            senddata_q <= 1'b0;
            timer_q    <= '0;
            sent_q     <= 16'h0000;
            tmo_q      <= 1'b0;
            rr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            txbyte_q   <= txbyte_d;
            tx_src_q   <= tx_src_d;
            senddata_q <= senddata_d;
            timer_q    <= timer_d;
            sent_q     <= sent_d;
            tmo_q      <= tmo_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign req_ready  = req_ready_s;
    assign txbyte     = txbyte_q;
    assign tx_src     = tx_src_q;
    assign senddata   = senddata_q;
    assign busy       = (state_q == ARB_BUSY) || !fifo_empty_s;
    assign fifo_count = fifo_count_s;
    assign sent_count = sent_q;
    assign tx_timeout = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=2, DEPTH=8, TIMEOUT=4096).
module tb_uart_tx_arbiter;

    localparam int TIMEOUT = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [7:0]  txbyte;
    logic        senddata;
    logic        txdone;
    logic [0:0]  tx_src;
    logic        busy;
    logic [3:0]  fifo_count;
    logic [15:0] sent_count;
    logic        tx_timeout;

    int n_asserts = 0;
    int n_fail    = 0;

    logic [7:0] d0, d1;
    logic [7:0] exp_bytes [3];
    logic       exp_srcs  [3];

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ    (2),
        .DEPTH   (8),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .txbyte     (txbyte),
        .senddata   (senddata),
        .txdone     (txdone),
        .tx_src     (tx_src),
        .busy       (busy),
        .fifo_count (fifo_count),
        .sent_count (sent_count),
        .tx_timeout (tx_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = 2'b00;
        req_data  = 16'h0000;
        txdone    = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_txdone();
        txdone = 1'b1;
        step();
        txdone = 1'b0;
    endtask

    initial begin
        // Reset values
        do_reset();
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_txbyte", 32'(txbyte), 32'h0);
        check("rst_senddata", 32'(senddata), 32'h0);
        check("rst_tx_src", 32'(tx_src), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_fifo_count", 32'(fifo_count), 32'h0);
        check("rst_sent_count", 32'(sent_count), 32'h0);
        check("rst_tx_timeout", 32'(tx_timeout), 32'h0);

        // Single byte from requester 0
        req_valid = 2'b01;
        req_data  = 16'h0041;
        #1;
        check("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = 2'b00;
        check("single_queued", 32'(fifo_count), 32'h1);
        check("single_no_send_yet", 32'(senddata), 32'h0);
        step();
        check("single_send", 32'(senddata), 32'h1);
        check("single_txbyte", 32'(txbyte), 32'h41);
        check("single_tx_src", 32'(tx_src), 32'h0);
        check("single_popped", 32'(fifo_count), 32'h0);
        check("single_busy", 32'(busy), 32'h1);
        step();
        check("single_send_one_cycle", 32'(senddata), 32'h0);
        check("single_txbyte_hold", 32'(txbyte), 32'h41);
        step();
        step();
        pulse_txdone();
        check("single_sent_count", 32'(sent_count), 32'h1);
        check("single_idle", 32'(busy), 32'h0);

        // Round-robin fairness
        do_reset();
        req_valid = 2'b10;
        req_data  = 16'hB0A0;
        #1;
        check("rr_only_valid_granted", 32'(req_ready), 32'h2);
        req_valid = 2'b11;
        d0 = 8'hA0;
        d1 = 8'hB0;
        for (int i = 0; i < 4; i++) begin
            req_data = {d1, d0};
            #1;
            check("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            if (i % 2 == 0) d0 = d0 + 8'h01;
            else            d1 = d1 + 8'h01;
        end
        req_valid = 2'b00;
        check("rr_first_byte", 32'(txbyte), 32'hA0);
        check("rr_first_src", 32'(tx_src), 32'h0);
        check("rr_queued", 32'(fifo_count), 32'h3);
        exp_bytes[0] = 8'hB0; exp_srcs[0] = 1'b1;
        exp_bytes[1] = 8'hA1; exp_srcs[1] = 1'b0;
        exp_bytes[2] = 8'hB1; exp_srcs[2] = 1'b1;
        for (int j = 0; j < 3; j++) begin
            pulse_txdone();
            check("rr_reload_send", 32'(senddata), 32'h1);
            check("rr_order_byte", 32'(txbyte), 32'(exp_bytes[j]));
            check("rr_order_src", 32'(tx_src), 32'(exp_srcs[j]));
            step();
        end
        pulse_txdone();
        check("rr_sent_count", 32'(sent_count), 32'h4);
        check("rr_idle", 32'(busy), 32'h0);

        // Full FIFO with txdone withheld
        do_reset();
        req_valid = 2'b01;
        d0 = 8'hC0;
        for (int i = 0; i < 9; i++) begin
            req_data = {8'h00, d0};
            #1;
            check("full_accept", 32'(req_ready), 32'h1);
            step();
            d0 = d0 + 8'h01;
        end
        req_data = {8'h00, d0};
        #1;
        check("full_count", 32'(fifo_count), 32'h8);
        check("full_ready_low", 32'(req_ready), 32'h0);
        check("full_loaded_byte", 32'(txbyte), 32'hC0);
        txdone = 1'b1;
        #1;
        check("full_pop_allows_push", 32'(req_ready), 32'h1);
        step();
        txdone    = 1'b0;
        req_valid = 2'b00;
        check("full_b2b_send", 32'(senddata), 32'h1);
        check("full_b2b_byte", 32'(txbyte), 32'hC1);
        check("full_count_kept", 32'(fifo_count), 32'h8);
        check("full_busy", 32'(busy), 32'h1);
        check("full_sent_count", 32'(sent_count), 32'h1);

        // Timeout with no txdone after the C1 load
        repeat (TIMEOUT - 1) step();
        check("tmo_not_yet", 32'(tx_timeout), 32'h0);
        step();
        check("tmo_set", 32'(tx_timeout), 32'h1);
        check("tmo_no_send", 32'(senddata), 32'h0);
        check("tmo_sent_unchanged", 32'(sent_count), 32'h1);
        check("tmo_fifo_kept", 32'(fifo_count), 32'h8);
        step();
        check("tmo_next_load_send", 32'(senddata), 32'h1);
        check("tmo_next_load_byte", 32'(txbyte), 32'hC2);
        check("tmo_next_load_count", 32'(fifo_count), 32'h7);
        step();
        pulse_txdone();
        check("tmo_after_done_sent", 32'(sent_count), 32'h2);
        check("tmo_sticky", 32'(tx_timeout), 32'h1);
        check("tmo_reload_byte", 32'(txbyte), 32'hC3);

        // Reset while busy with bytes queued
        req_valid = 2'b01;
        req_data  = 16'h0055;
        rst       = 1'b1;
        step();
        check("mid_rst_fifo_count", 32'(fifo_count), 32'h0);
        check("mid_rst_senddata", 32'(senddata), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_req_ready", 32'(req_ready), 32'h0);
        check("mid_rst_tx_timeout", 32'(tx_timeout), 32'h0);
        rst       = 1'b0;
        req_valid = 2'b00;
        pulse_txdone();
        check("mid_rst_stray_done", 32'(sent_count), 32'h0);
        check("mid_rst_stray_send", 32'(senddata), 32'h0);

        // Spurious txdone pulses while idle
        for (int k = 0; k < 3; k++) begin
            pulse_txdone();
            step();
            check("idle_done_sent", 32'(sent_count), 32'h0);
            check("idle_done_send", 32'(senddata), 32'h0);
            check("idle_done_busy", 32'(busy), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
